dmem_write_buffer: RTL and testbench
====================================

Name: dmem_write_buffer

Overview:
- Responder end of the CPU data-memory port: word-addressed data memory behind a small write buffer with throttled drain.
- Takes the address, write-enable and write-data the CPU drives each cycle. Returns read data combinationally, so the single-cycle core needs no stall.
- Writes are queued and committed to the backing array at most once every DRAIN_CYCLES cycles. Reads forward from the buffer, so the buffer is invisible to software.

Parameters:
- ADDR_W, 8, word-index width; backing array holds 2^ADDR_W 32-bit words.
- WBUF_DEPTH, 4, buffer entries; power of two, at least 2.
- CNT_W, 3, width of wbuf_count; equals log2(WBUF_DEPTH)+1.
- DRAIN_CYCLES, 4, cycles between normal drains; at least 1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_memory_a  in  32  byte address; only bits [ADDR_W+1:2] are used.
- data_memory_we  in  1  write strobe, sampled at posedge.
- data_memory_wd  in  32  write data.
- data_memory_rd  out  32  combinational read data.
- flush  in  1  while high, drain one entry every cycle.
- wbuf_count  out  CNT_W  number of valid entries.
- wbuf_full  out  1  high when wbuf_count == WBUF_DEPTH.
- wbuf_empty  out  1  high when wbuf_count == 0.

Behaviour:
- Reset (async, rst_n low):
  - head, tail, count and drain timer go to 0; all entries are invalidated.
  - wbuf_count=0, wbuf_empty=1, wbuf_full=0.
  - Backing array is not touched.
  - Buffered writes pending at reset are discarded.
- Read path:
  - data_memory_rd = data of the newest valid entry whose word index equals data_memory_a[ADDR_W+1:2]; if none matches, mem[index].
  - Purely combinational, zero latency.
  - A write presented in cycle N is readable from cycle N+1 onward.
- Write enqueue (we=1 at posedge): {index, wd} is appended at tail; count +1.
- Drain timer:
  - Held at 0 while the buffer is empty.
  - Otherwise increments each cycle.
  - When it equals DRAIN_CYCLES-1: the head entry is written to mem, head advances, count -1, timer returns to 0.
- Flush: while flush=1 and the buffer is non-empty, the head drains every cycle regardless of the timer, and the timer is held at 0.
- Full and write in the same cycle (write does not coalesce):
  - Forced drain of the head on that edge, and the new entry is enqueued.
  - Count stays WBUF_DEPTH; timer is reset to 0.
  - No write is ever lost.
- Drain (normal or flush) and enqueue in the same cycle: both happen; count unchanged.
- Pointers wrap modulo WBUF_DEPTH.
- Ordering: the backing array receives writes in program order; at most one array write per cycle.

Optional Feature:
- Macro: WBUF_COALESCE_EN.
- Defined:
  - A write whose index matches a valid entry overwrites that entry's data in place.
  - No enqueue, count unchanged, no forced drain even when full.
  - If the matched entry is the head and it drains on the same edge, the array receives the new wd and the entry pops.
- Undefined:
  - Every write is appended, and duplicate indices may coexist.
  - Read forwarding selects the newest match, by age from head.

Test Plan:
1. Reset, write 0xDEADBEEF to address 0x10, then idle (we=0). Required:
   - Next cycle rd at 0x10 = 0xDEADBEEF and wbuf_count=1.
   - mem[4] is written after 4 cycles; count returns to 0 and rd still shows 0xDEADBEEF.
2. Five back-to-back writes (0x0,0x4,0x8,0xC,0x10 with data 1..5), DEPTH=4. Required:
   - Fifth write forces drain of entry 0x0; wbuf_full=1 and count=4.
   - All five addresses read back 1..5.
3. With WBUF_COALESCE_EN, write 0x20=0xA then 0x20=0xB. Required:
   - Count stays 1 and rd at 0x20 = 0xB; the array receives only 0xB.
   - Without the macro: count=2, rd=0xB, and the array receives 0xA then 0xB.
4. Fill 3 entries, then assert flush for 3 cycles. Required: count goes 3,2,1,0, one array write per cycle, in order.
5. Fill 2 entries, then pulse rst_n low mid-drain. Required:
   - count=0 and wbuf_empty=1 immediately, without waiting for a clock.
   - Reads return the old array contents; the discarded writes never appear.
6. Write on the exact cycle the timer expires, with 1 entry buffered. Required: head drains and new entry enqueues; count stays 1; timer restarts at 0.

Source files
------------

// File: rtl/dmem_write_buffer.sv
// rtl/dmem_write_buffer.sv - data-memory responder with a throttled-drain write buffer.
// Optional: define WBUF_COALESCE_EN to merge writes to an index already held in the buffer.
module dmem_write_buffer #(
  parameter int ADDR_W       = 8,
  parameter int WBUF_DEPTH   = 4,
  parameter int CNT_W        = 3,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       data_memory_a,
  input  logic              data_memory_we,
  input  logic [31:0]       data_memory_wd,
  output logic [31:0]       data_memory_rd,
  input  logic              flush,
  output logic [CNT_W-1:0]  wbuf_count,
  output logic              wbuf_full,
  output logic              wbuf_empty
);

  localparam int PTR_W   = $clog2(WBUF_DEPTH);
  localparam int TIMER_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DRAIN_CYCLES - 1);

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [TIMER_W-1:0] timer;
  logic [WBUF_DEPTH-1:0] valid;
  logic [ADDR_W-1:0]  entry_idx  [WBUF_DEPTH];
  logic [31:0]        entry_data [WBUF_DEPTH];
  logic [31:0]        mem        [2**ADDR_W];

  logic [ADDR_W-1:0]  idx;
  logic               unused_addr_bits;
  logic               empty;
  logic               full;
  logic               wr_hit;
  logic [PTR_W-1:0]   hit_pos;
  logic               enq;
  logic               drain;
  logic [31:0]        drain_data;

  assign idx              = data_memory_a[ADDR_W+1:2];
  assign unused_addr_bits = ^{data_memory_a[31:ADDR_W+2], data_memory_a[1:0]};
  assign empty            = (count == '0);
  assign full             = (count == CNT_W'(WBUF_DEPTH));

`ifdef WBUF_COALESCE_EN
  // At most one valid entry can hold a given index when writes coalesce.
  always_comb begin
    wr_hit  = 1'b0;
    hit_pos = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (valid[i] && entry_idx[i] == idx) begin
        wr_hit  = 1'b1;
        hit_pos = PTR_W'(i);
      end
    end
  end
`else
  assign wr_hit  = 1'b0;
  assign hit_pos = '0;
`endif

  assign enq   = data_memory_we && !wr_hit;
  assign drain = !empty && (flush || (timer == TIMER_LAST) || (full && enq));

  // A coalesced write into the head that pops on this edge must reach the array.
  assign drain_data = (data_memory_we && wr_hit && hit_pos == head) ? data_memory_wd
                                                                     : entry_data[head];

  // Scan oldest to newest so the last match seen is the youngest copy.
  always_comb begin
    logic [PTR_W-1:0] pos;
    pos            = '0;
    data_memory_rd = mem[idx];
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      pos = head + PTR_W'(i);
      if (valid[pos] && entry_idx[pos] == idx) begin
        data_memory_rd = entry_data[pos];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      timer <= '0;
      valid <= '0;
    end else begin
      if (drain) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      // When full, head == tail, so this set overrides the clear above.
      if (enq) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      case ({enq, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (empty || drain) begin
        timer <= '0;
      end else begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      entry_idx[tail]  <= idx;
      entry_data[tail] <= data_memory_wd;
    end
    if (data_memory_we && wr_hit) begin
      entry_data[hit_pos] <= data_memory_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (drain) begin
      mem[entry_idx[head]] <= drain_data;
    end
  end

  assign wbuf_count = count;
  assign wbuf_full  = full;
  assign wbuf_empty = empty;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb/tb_dmem_write_buffer.sv - scoreboard bench for dmem_write_buffer.
module tb_dmem_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  dmem_write_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .data_memory_a(a), .data_memory_we(we), .data_memory_wd(wd), .data_memory_rd(rd),
    .flush(flush), .wbuf_count(count), .wbuf_full(full), .wbuf_empty(empty)
  );

  always #5 clk = ~clk;

  localparam int K_RD = 0, K_CNT = 1, K_FULL = 2, K_EMPTY = 3;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    a  = addr;
    wd = data;
    we = 1'b1;
    tick();
  endtask

  task automatic chk(input string name, input int kind, input logic [31:0] addr,
                     input logic [31:0] exp);
    if (kind == K_RD) a = addr;
    #1;
    n_cmp++;
    case (kind)
      K_RD: begin
        if (rd !== exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", name, rd, exp);
        end
      end
      K_CNT: begin
        if ({29'b0, count} !== exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", name, count, exp);
        end
      end
      K_FULL: begin
        if ({31'b0, full} !== exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", name, full, exp);
        end
      end
      default: begin
        if ({31'b0, empty} !== exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", name, empty, exp);
        end
      end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    chk("rst_count", K_CNT, 0, 0);
    chk("rst_empty", K_EMPTY, 0, 1);
    chk("rst_full", K_FULL, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    wr(32'h10, 32'hDEADBEEF);
    chk("t1_fwd", K_RD, 32'h10, 32'hDEADBEEF);
    chk("t1_cnt1", K_CNT, 0, 1);
    tick(); tick(); tick();
    chk("t1_cnt_pre", K_CNT, 0, 1);
    tick();
    chk("t1_cnt0", K_CNT, 0, 0);
    chk("t1_mem", K_RD, 32'h10, 32'hDEADBEEF);

    for (int i = 0; i < 5; i++) wr(32'(i * 4), 32'(i + 1));
    chk("t2_cnt", K_CNT, 0, 4);
    chk("t2_full", K_FULL, 0, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_rd%0d", i), K_RD, 32'(i * 4), 32'(i + 1));
    flush = 1'b1;
    tick(); tick(); tick(); tick();
    flush = 1'b0;
    chk("t2_empty", K_EMPTY, 0, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_mem%0d", i), K_RD, 32'(i * 4), 32'(i + 1));

    wr(32'h20, 32'hA);
    wr(32'h20, 32'hB);
`ifdef WBUF_COALESCE_EN
    chk("t3_cnt", K_CNT, 0, 1);
`else
    chk("t3_cnt", K_CNT, 0, 2);
`endif
    chk("t3_fwd", K_RD, 32'h20, 32'hB);
    flush = 1'b1;
    tick(); tick();
    flush = 1'b0;
    chk("t3_empty", K_EMPTY, 0, 1);
    chk("t3_mem", K_RD, 32'h20, 32'hB);

    wr(32'h40, 32'h100);
    wr(32'h44, 32'h200);
    wr(32'h48, 32'h300);
    chk("t4_cnt3", K_CNT, 0, 3);
    flush = 1'b1;
    tick();
    chk("t4_cnt2", K_CNT, 0, 2);
    tick();
    chk("t4_cnt1", K_CNT, 0, 1);
    tick();
    chk("t4_cnt0", K_CNT, 0, 0);
    flush = 1'b0;
    chk("t4_rd40", K_RD, 32'h40, 32'h100);
    chk("t4_rd44", K_RD, 32'h44, 32'h200);
    chk("t4_rd48", K_RD, 32'h48, 32'h300);

    wr(32'h60, 32'h11);
    tick(); tick(); tick();
    wr(32'h64, 32'h22);
    chk("t6_cnt", K_CNT, 0, 1);
    chk("t6_rd60", K_RD, 32'h60, 32'h11);
    chk("t6_rd64", K_RD, 32'h64, 32'h22);
    tick(); tick(); tick();
    chk("t6_cnt_hold", K_CNT, 0, 1);
    tick();
    chk("t6_cnt0", K_CNT, 0, 0);
    chk("t6_mem64", K_RD, 32'h64, 32'h22);

    wr(32'h80, 32'hAAAA);
    wr(32'h84, 32'hBBBB);
    flush = 1'b1;
    tick(); tick();
    flush = 1'b0;
    wr(32'h80, 32'hDEAD1);
    wr(32'h84, 32'hDEAD2);
    tick();
    rst_n = 1'b0;
    chk("t5_cnt", K_CNT, 0, 0);
    chk("t5_empty", K_EMPTY, 0, 1);
    chk("t5_rd80", K_RD, 32'h80, 32'hAAAA);
    chk("t5_rd84", K_RD, 32'h84, 32'hBBBB);
    #1;
    rst_n = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("t5_rd80_late", K_RD, 32'h80, 32'hAAAA);
    chk("t5_rd84_late", K_RD, 32'h84, 32'hBBBB);

    #20;
    if (n_cmp < 12) begin
      n_bad++;
      $display("FAIL check_count: got %0d expected at least 12", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
